ep_chn_arb: RTL and testbench
=============================

// Module: ep_chn_arb
// PURPOSE
//  Round-robin token arbiter that shares the PCIe endpoint TRN tx interface among NCH channel
//  instances. Each channel raises chn_reqep; the arbiter grants exactly one via one-hot chn_trn.
//  The grantee signals ownership with chn_drvn. Channel TRN tx outputs are merged by OR/AND at top
//  level, so at most one grant may exist at a time. Sits in the top level, pcie_clk domain.
// PARAMETERS
//  NCH    3    number of requesting channels (2..8)
//  IW     2    width of grant index, >= clog2(NCH)
//  TMO    255  cycles a grant may wait for chn_drvn before being revoked (1..65535)
// PORTS
//  clk          in   1    pcie_clk
//  rst_n        in   1    asynchronous reset, active-low
//  chn_reqep    in   NCH  per-channel request for the endpoint (level)
//  chn_drvn     in   NCH  per-channel "driving TRN tx" indication
//  chn_trn      out  NCH  one-hot grant (registered)
//  gnt_vld      out  1    a grant is outstanding (= |chn_trn)
//  gnt_id       out  IW   index of granted channel; holds last value when gnt_vld=0
//  tmo_err      out  1    one-cycle pulse: grant revoked by timeout
//  proto_err    out  1    sticky: chn_drvn seen from a non-granted channel; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, chn_trn=0, gnt_vld=0, gnt_id=NCH-1 (so ch0 wins first),
//   tmo_err=0, proto_err=0, timeout counter=0. All outputs registered.
//  States: IDLE, GRANT, OWN, GAP.
//  IDLE: if |chn_reqep: pick first requester scanning from gnt_id+1 upward, wrapping at NCH-1->0;
//   set chn_trn[i]=1, gnt_id=i, clear counter, ->GRANT. Grant visible the cycle after request seen.
//   No requester: stay IDLE.
//  GRANT: counter increments each cycle.
//   chn_drvn[i]=1 -> OWN (takes priority over all below in the same cycle).
//   else chn_reqep[i]=0 (request withdrawn) -> drop chn_trn, ->GAP, no error.
//   else counter==TMO-1 -> drop chn_trn, pulse tmo_err, ->GAP.
//  OWN: hold grant while chn_drvn[i]=1. chn_drvn[i] falls -> chn_trn=0 next edge, ->GAP.
//   chn_reqep[i] is ignored in OWN; no timeout in OWN (packets are unbounded).
//  GAP: exactly one idle cycle, no grant, ->IDLE. Guarantees a dead cycle on merged TRN bus.
//  Timing: drvn falls seen at edge k -> chn_trn low after k; earliest next grant high after k+2.
//  Fairness: pointer (gnt_id) advances only on grant; a channel that keeps requesting waits at most
//   NCH-1 other grants. Single requester re-granted every 3 cycles minimum when it releases.
//  proto_err: set on any cycle where chn_drvn[j]=1 and (chn_trn[j]=0 or state==GAP), any j.
//   Its occurrence does not change arbitration.
//  Out-of-range indices (NCH < 2^IW) are never generated.
//  rst_n asserted mid-grant: grant removed immediately (async), channels must tolerate.
// TESTING
//  1 Reset, chn_reqep=3'b001 -> chn_trn=001 one cycle later, gnt_id=0; drvn pulses 10 cycles,
//    falls -> chn_trn=000 next cycle, regranted 001 two cycles after that.
//  2 chn_reqep=3'b111 held, each grantee drives 4 cycles -> grant sequence 0,1,2,0,1,2;
//    never two bits of chn_trn set; >=1 no-grant cycle between grants.
//  3 Grant ch1, never assert drvn, TMO=255 -> chn_trn drops after 255 grant cycles,
//    tmo_err high exactly 1 cycle, next grant goes to ch2 if requesting.
//  4 Grant ch2, ch2 drops reqep before drvn -> grant dropped next cycle, tmo_err=0, ->GAP->IDLE.
//  5 While ch0 owns, assert chn_drvn[1] one cycle -> proto_err=1 and stays 1; ch0 keeps grant.
//  6 rst_n low during OWN -> chn_trn=0 asynchronously; after release with reqep=111 first grant=ch0.

Source files
------------

// File: rtl/ep_chn_arb.sv
// Round-robin token arbiter sharing the endpoint TRN tx interface among NCH channels.
// At most one one-hot grant exists at any time, and every grant is followed by one
// dead cycle so the OR/AND-merged TRN bus never carries two drivers back to back.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | no grant; picks next requester after gnt_id, round-robin
//  ST_GRANT | grant issued, waiting for the grantee to drive (timeout armed)
//  ST_OWN   | grantee drives TRN tx; held until its chn_drvn falls
//  ST_GAP   | single dead cycle with no grant before returning to ST_IDLE
module ep_chn_arb #(
    parameter int NCH = 3,
    parameter int IW  = 2,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] chn_reqep,
    input  logic [NCH-1:0] chn_drvn,
    output logic [NCH-1:0] chn_trn,
    output logic           gnt_vld,
    output logic [IW-1:0]  gnt_id,
    output logic           tmo_err,
    output logic           proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWN   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    cnt;
    logic [15:0]    cnt_nxt;
    logic [NCH-1:0] trn_nxt;
    logic [IW-1:0]  id_nxt;
    logic           tmo_nxt;
    logic           proto_nxt;

    logic           hi_vld;
    logic           lo_vld;
    logic [IW-1:0]  hi_id;
    logic [IW-1:0]  lo_id;
    logic           pick_vld;
    logic [IW-1:0]  pick_id;

    // The grant is one-hot, so masking with it selects the grantee's own request/drive.
    logic own_drvn;
    logic own_req;
    logic proto_hit;

    assign own_drvn  = |(chn_drvn & chn_trn);
    assign own_req   = |(chn_reqep & chn_trn);
    assign proto_hit = (|(chn_drvn & ~chn_trn)) || ((state == ST_GAP) && (|chn_drvn));

    // Round-robin pick: lowest requester above gnt_id, else lowest at or below it (wrap).
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (chn_reqep[j]) begin
                if (j > int'(gnt_id)) begin
                    hi_vld = 1'b1;
                    hi_id  = IW'(j);
                end else begin
                    lo_vld = 1'b1;
                    lo_id  = IW'(j);
                end
            end
        end
        pick_vld = hi_vld | lo_vld;
        pick_id  = hi_vld ? hi_id : lo_id;
    end

    // Next-state and next-output decode; drive beats withdraw, withdraw beats timeout.
    always_comb begin
        state_nxt = state;
        trn_nxt   = chn_trn;
        id_nxt    = gnt_id;
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
        proto_nxt = proto_err | proto_hit;
        case (state)
            ST_IDLE: begin
                trn_nxt = '0;
                if (pick_vld) begin
                    trn_nxt   = NCH'(1) << pick_id;
                    id_nxt    = pick_id;
                    cnt_nxt   = '0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cnt_nxt = cnt + 16'd1;
                if (own_drvn) begin
                    state_nxt = ST_OWN;
                end else if (!own_req) begin
                    trn_nxt   = '0;
                    state_nxt = ST_GAP;
                end else if (cnt == 16'(TMO - 1)) begin
                    trn_nxt   = '0;
                    tmo_nxt   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_OWN: begin
                if (!own_drvn) begin
                    trn_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                trn_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                trn_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset pulls the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            chn_trn   <= '0;
            gnt_vld   <= 1'b0;
            gnt_id    <= IW'(NCH - 1);
            cnt       <= '0;
            tmo_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            chn_trn   <= trn_nxt;
            gnt_vld   <= |trn_nxt;
            gnt_id    <= id_nxt;
            cnt       <= cnt_nxt;
            tmo_err   <= tmo_nxt;
            proto_err <= proto_nxt;
        end
    end

endmodule

// File: tb/tb_ep_chn_arb.sv
// Bench for ep_chn_arb: a transaction-level model predicts each grant (channel, start
// cycle, length, timeout flag) and queues it; a monitor pops and compares on every grant.
module tb_ep_chn_arb;

    localparam int NCH = 3;
    localparam int IW  = 2;
    localparam int TMO = 255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] chn_reqep;
    logic [NCH-1:0] chn_drvn;
    logic [NCH-1:0] chn_trn;
    logic           gnt_vld;
    logic [IW-1:0]  gnt_id;
    logic           tmo_err;
    logic           proto_err;

    ep_chn_arb #(.NCH(NCH), .IW(IW), .TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chn_reqep (chn_reqep),
        .chn_drvn  (chn_drvn),
        .chn_trn   (chn_trn),
        .gnt_vld   (gnt_vld),
        .gnt_id    (gnt_id),
        .tmo_err   (tmo_err),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        int id;
        int dur;
        bit tmo;
        int start;
    } exp_t;

    exp_t q[$];
    bit   mon_en = 1'b0;
    int   ptr    = NCH - 1;

    // monitor-private state
    bit             m_in_g  = 1'b0;
    exp_t           m_cur;
    int             m_len   = 0;
    int             m_last  = NCH - 1;
    logic [NCH-1:0] m_held  = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference: first requester after p, wrapping modulo NCH
    function automatic int next_id(input logic [NCH-1:0] r, input int p);
        int c;
        next_id = -1;
        for (int k = 1; k <= NCH; k++) begin
            c = (p + k) % NCH;
            if (next_id < 0 && r[c[IW-1:0]]) next_id = c;
        end
    endfunction

    // kind: 0 = grantee drives l cycles after d idle grant cycles, 1 = withdraws after d, 2 = timeout
    task automatic run_round(input logic [NCH-1:0] r, input int kind, input int d,
                             input int l, input int idle, input bit inject);
        int   e;
        int   o;
        exp_t x;
        e = next_id(r, ptr);
        ptr = e;
        o = (e + 1) % NCH;
        x.id    = e;
        x.dur   = (kind == 0) ? d + l + 1 : (kind == 1) ? d + 1 : TMO;
        x.tmo   = (kind == 2);
        x.start = cyc + 1;
        q.push_back(x);
        chn_reqep = r;
        chn_drvn  = '0;
        @(negedge clk);
        if (kind == 0) begin
            repeat (d) @(negedge clk);
            chn_drvn[e[IW-1:0]] = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (inject && i == 1) chn_drvn[o[IW-1:0]] = 1'b1;
                if (inject && i == 2) chn_drvn[o[IW-1:0]] = 1'b0;
                @(negedge clk);
            end
            chn_drvn = '0;
            @(negedge clk);
        end else if (kind == 1) begin
            repeat (d) @(negedge clk);
            chn_reqep[e[IW-1:0]] = 1'b0;
            @(negedge clk);
        end else begin
            repeat (TMO) @(negedge clk);
        end
        chn_reqep = '0;
        @(negedge clk);
        repeat (idle) @(negedge clk);
    endtask

    // Monitor: pops one expectation per grant and checks it against what the DUT shows.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) m_last = NCH - 1;
            if (!mon_en || !rst_n) begin
                m_in_g = 1'b0;
            end else begin
                chk("onehot", int'($countones(chn_trn) <= 1), 1);
                chk("gnt_vld", int'(gnt_vld), int'(|chn_trn));
                if (chn_trn != '0 && !m_in_g) begin
                    if (q.size() == 0) begin
                        chk("unexpected_grant", int'(chn_trn), 0);
                        m_cur = '{id: -1, dur: 0, tmo: 1'b0, start: 0};
                    end else begin
                        m_cur = q.pop_front();
                        chk("grant_id", int'(gnt_id), m_cur.id);
                        chk("grant_vec", int'(chn_trn), 1 << m_cur.id);
                        chk("grant_start", cyc, m_cur.start);
                    end
                    chk("tmo_err_in_grant", int'(tmo_err), 0);
                    m_last = m_cur.id;
                    m_in_g = 1'b1;
                    m_len  = 1;
                    m_held = chn_trn;
                end else if (chn_trn != '0) begin
                    m_len++;
                    chk("grant_stable", int'(chn_trn), int'(m_held));
                    chk("tmo_err_in_grant", int'(tmo_err), 0);
                end else if (m_in_g) begin
                    m_in_g = 1'b0;
                    chk("grant_len", m_len, m_cur.dur);
                    chk("tmo_err_at_drop", int'(tmo_err), int'(m_cur.tmo));
                    chk("idle_gnt_id", int'(gnt_id), m_last);
                end else begin
                    chk("tmo_err_idle", int'(tmo_err), 0);
                    chk("idle_gnt_id", int'(gnt_id), m_last);
                end
            end
        end
    end

    // Stimulus: directed scenarios, randomized rounds, then sticky error and async reset.
    initial begin
        logic [NCH-1:0] r;
        int             sel;
        int             kind;
        int             e;

        rst_n     = 1'b0;
        chn_reqep = '0;
        chn_drvn  = '0;
        repeat (3) @(negedge clk);
        chk("rst_chn_trn", int'(chn_trn), 0);
        chk("rst_gnt_vld", int'(gnt_vld), 0);
        chk("rst_gnt_id", int'(gnt_id), NCH - 1);
        chk("rst_tmo_err", int'(tmo_err), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single requester: long packet, then fastest possible regrant
        run_round(3'b001, 0, 0, 10, 0, 1'b0);
        run_round(3'b001, 0, 0, 4, 0, 1'b0);

        // all requesting: strict rotation
        for (int i = 0; i < 6; i++) run_round(3'b111, 0, 0, 4, 0, 1'b0);

        // timeout on ch1, then ch2 next
        run_round(3'b010, 2, 0, 0, 0, 1'b0);
        run_round(3'b110, 0, 1, 2, 0, 1'b0);

        // ch2 withdraws before driving
        run_round(3'b100, 1, 2, 0, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r    = NCH'($urandom_range(1, (1 << NCH) - 1));
            sel  = int'($urandom_range(0, 11));
            kind = (sel < 7) ? 0 : (sel < 11) ? 1 : 2;
            run_round(r, kind, int'($urandom_range(0, 6)), int'($urandom_range(1, 8)),
                      int'($urandom_range(0, 2)), 1'b0);
        end

        // foreign drive while a grantee owns the bus
        chk("proto_clear", int'(proto_err), 0);
        run_round(3'b011, 0, 1, 5, 0, 1'b1);
        chk("proto_set", int'(proto_err), 1);
        run_round(3'b111, 0, 0, 3, 0, 1'b0);
        chk("proto_sticky", int'(proto_err), 1);

        // asynchronous reset in the middle of ownership
        mon_en    = 1'b0;
        e         = next_id(3'b111, ptr);
        chn_reqep = 3'b111;
        @(negedge clk);
        chn_drvn[e[IW-1:0]] = 1'b1;
        repeat (3) @(negedge clk);
        chk("own_before_reset", int'(chn_trn), 1 << e);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_chn_trn", int'(chn_trn), 0);
        chk("async_rst_gnt_vld", int'(gnt_vld), 0);
        chk("async_rst_gnt_id", int'(gnt_id), NCH - 1);
        chk("async_rst_proto", int'(proto_err), 0);
        chn_drvn  = '0;
        chn_reqep = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        ptr    = NCH - 1;
        mon_en = 1'b1;
        run_round(3'b111, 0, 0, 3, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
